// File: rtl/zx_key_injector_if.sv
// zx_key_injector_if: host/CPU-side bundle of the ZX keystroke injector.
//   master: host/loader side (drives memory writes, start/abort, row_sel)
//   slave : injector side (drives keys, kb_data, busy, done, cur_index)
// Ports: wr_en/wr_addr/wr_data (sequence memory write), seq_len, start, abort,
//        row_sel (CPU row select), kb_data (column read), keys (matrix),
//        busy, done, cur_index.
interface zx_key_injector_if #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 5,
  parameter int unsigned AW   = 7
);
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [15:0]          wr_data;
  logic [AW:0]          seq_len;
  logic                 start;
  logic                 abort;
  logic [ROWS-1:0]      row_sel;
  logic [COLS-1:0]      kb_data;
  logic [ROWS*COLS-1:0] keys;
  logic                 busy;
  logic                 done;
  logic [AW-1:0]        cur_index;

  modport master (
    output wr_en, wr_addr, wr_data, seq_len, start, abort, row_sel,
    input  kb_data, keys, busy, done, cur_index
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, seq_len, start, abort, row_sel,
    output kb_data, keys, busy, done, cur_index
  );
endinterface

// File: rtl/zx_key_injector.sv
// zx_key_injector: plays a host-loaded table of key codes into an active-low
// ROWS x COLS ZX Spectrum keyboard matrix with programmable press/release
// durations, and serves the matrix to the CPU as a row-select/column-read port.
// Ports: clk, reset (async active-low), bus (zx_key_injector_if.slave).
// Entry format: [15:8] row, [7] pause, [6] caps shift, [5] symbol shift,
//               [4:0] active-low column mask.
// Optional: define ZX_KEY_INJECTOR_AUTOSTART_EN to leave reset in WAIT and
//           start automatically after START_CYC clocks.
module zx_key_injector #(
  parameter int unsigned ROWS        = 8,
  parameter int unsigned COLS        = 5,
  parameter int unsigned DEPTH       = 128,
  parameter int unsigned AW          = $clog2(DEPTH),
  parameter int unsigned PRESS_CYC   = 2700000,
  parameter int unsigned RELEASE_CYC = 2700000,
  parameter int unsigned START_CYC   = 81000000
) (
  input  logic             clk,
  input  logic             reset,
  zx_key_injector_if.slave bus
);

  localparam int unsigned   LW      = AW + 1;
  localparam int unsigned   KW      = ROWS * COLS;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [KW-1:0] KEYS_UP = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_FETCH, S_LOAD, S_PRESS, S_RELEASE, S_DONE
  } state_t;

`ifdef ZX_KEY_INJECTOR_AUTOSTART_EN
  localparam state_t RESET_STATE = S_WAIT;
`else
  localparam state_t RESET_STATE = S_IDLE;
`endif

  state_t          r_state, w_state;
  logic [31:0]     r_timer, w_timer;
  logic [LW-1:0]   r_len, w_len;
  logic [AW-1:0]   r_index, w_index;
  logic [KW-1:0]   r_keys, w_keys;
  logic            r_busy, r_done;
  logic [15:0]     r_mem [DEPTH];
  logic [15:0]     r_rd_data;
  logic [LW-1:0]   w_len_clamped;
  logic            w_go;
  logic [KW-1:0]   w_entry_keys;
  logic [COLS-1:0] w_kb;

  assign w_len_clamped = (bus.seq_len > DEPTH_L) ? DEPTH_L : bus.seq_len;

  // Sequence memory: host writes only while idle; read port is registered.
  always_ff @(posedge clk) begin
    if (bus.wr_en && (r_state == S_IDLE)) r_mem[bus.wr_addr] <= bus.wr_data;
    r_rd_data <= r_mem[r_index];
  end

  // Decode the fetched entry into a full matrix image.
  always_comb begin
    w_entry_keys = KEYS_UP;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (r_rd_data[15:8] == 8'(r)) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          if (c < 5) w_entry_keys[r*COLS + c] = r_rd_data[c];
        end
      end
    end
    if (r_rd_data[6]) w_entry_keys[0] = 1'b0;                // caps shift
    if (r_rd_data[5]) w_entry_keys[(ROWS-1)*COLS + 1] = 1'b0; // symbol shift
    if (r_rd_data[7]) w_entry_keys = KEYS_UP;                 // pause slot
  end

  // Start request: explicit start in IDLE (abort wins), or start/timeout in WAIT.
  assign w_go = ((r_state == S_IDLE) && bus.start && !bus.abort) ||
                ((r_state == S_WAIT) && (bus.start || (r_timer == 32'(START_CYC))));

  // Next-state and next-output logic.
  always_comb begin
    w_state = r_state;
    w_len   = r_len;
    w_index = r_index;
    w_keys  = r_keys;
    case (r_state)
      S_IDLE, S_WAIT: begin
        if (w_go) begin
          w_len = w_len_clamped;
          if (w_len_clamped == '0) begin
            w_state = S_DONE;
          end else begin
            w_index = '0;
            w_state = S_FETCH;
          end
        end
      end
      S_FETCH: w_state = S_LOAD;
      S_LOAD: begin
        w_keys  = w_entry_keys;
        w_state = S_PRESS;
      end
      S_PRESS: begin
        if (r_timer == 32'(PRESS_CYC - 1)) begin
          w_keys  = KEYS_UP;
          w_state = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (r_timer == 32'(RELEASE_CYC - 1)) begin
          if ((LW'(r_index) + LW'(1)) < r_len) begin
            w_index = r_index + AW'(1);
            w_state = S_FETCH;
          end else begin
            w_state = S_DONE;
          end
        end
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
    if ((r_state != S_IDLE) && bus.abort) begin
      w_state = S_IDLE;
      w_keys  = KEYS_UP;
    end
    // Timer restarts from zero on every state entry.
    w_timer = (w_state != r_state) ? 32'd0 : r_timer + 32'd1;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RESET_STATE;
      r_timer <= '0;
      r_len   <= '0;
      r_index <= '0;
      r_keys  <= KEYS_UP;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_timer <= w_timer;
      r_len   <= w_len;
      r_index <= w_index;
      r_keys  <= w_keys;
      r_busy  <= (w_state != S_IDLE);
      r_done  <= (w_state == S_DONE);
    end
  end

  // CPU column read: AND of every selected row, all ones when none selected.
  always_comb begin
    w_kb = '1;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (!bus.row_sel[r]) w_kb = w_kb & r_keys[r*COLS +: COLS];
    end
  end

  assign bus.kb_data   = w_kb;
  assign bus.keys      = r_keys;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.cur_index = r_index;

endmodule

// File: tb/tb_zx_key_injector.sv
// tb_zx_key_injector: directed self-checking bench for zx_key_injector
// (default build, PRESS_CYC=4, RELEASE_CYC=3).
module tb_zx_key_injector;

  localparam logic [39:0] ALL1 = '1;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  zx_key_injector_if #(.ROWS(8), .COLS(5), .AW(7)) bus ();

  zx_key_injector #(
    .ROWS(8), .COLS(5), .DEPTH(128), .AW(7),
    .PRESS_CYC(4), .RELEASE_CYC(3), .START_CYC(10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All keys up except row r, which holds v.
  function automatic logic [39:0] mk(input int r, input logic [4:0] v);
    logic [39:0] k;
    k = ALL1;
    k[r*5 +: 5] = v;
    return k;
  endfunction

  task automatic wr(input logic [6:0] a, input logic [15:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // Write entry 0 and start in the same cycle; returns at clock 1 after start.
  task automatic launch(input logic [15:0] d, input logic [7:0] len);
    bus.wr_en = 1'b1; bus.wr_addr = 7'd0; bus.wr_data = d;
    bus.seq_len = len; bus.start = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0; bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 64'(bus.busy), 64'(0));
    @(negedge clk);
  endtask

  task automatic play1(input string tag, input logic [15:0] d, input logic [39:0] exp);
    launch(d, 8'd1);
    repeat (2) @(negedge clk);
    check(tag, 64'(bus.keys), 64'(exp));
    wait_idle();
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    reset = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.seq_len = '0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.row_sel = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_keys", 64'(bus.keys), 64'(ALL1));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_idx",  64'(bus.cur_index), 64'(0));
    reset = 1'b1;

    // No key before start in the default build.
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      check("idle_nokey", 64'(bus.keys), 64'(ALL1));
    end

    // Single entry timing: row 2 = 10000 on clocks 3..6, done on clock 10.
    launch(16'h0210, 8'd1);
    for (int k = 1; k <= 12; k++) begin
      check("t1_keys", 64'(bus.keys), 64'((k >= 3 && k <= 6) ? mk(2, 5'b10000) : ALL1));
      check("t1_done", 64'(bus.done), 64'(k == 10));
      check("t1_busy", 64'(bus.busy), 64'(k <= 10));
      @(negedge clk);
    end

    // Shift keys and out-of-range row.
    play1("cs_row0", 16'h0055, mk(0, 5'b10100));
    play1("ss_only", 16'h0820, mk(7, 5'b11101));

    // Three-entry run with pause slot; mid-run start and write are ignored.
    wr(7'd1, 16'h0080);
    wr(7'd2, 16'h011E);
    launch(16'h0301, 8'd3);
    for (int k = 1; k <= 29; k++) begin
      int          i;
      int          p;
      logic [39:0] e;
      i = (k - 1) / 9;
      p = (k - 1) % 9;
      e = ALL1;
      if (k <= 27 && p >= 2 && p <= 5) begin
        if (i == 0) e = mk(3, 5'b00001);
        else if (i == 2) e = mk(1, 5'b11110);
      end
      check("t3_keys", 64'(bus.keys), 64'(e));
      check("t3_idx",  64'(bus.cur_index), 64'((k <= 27) ? i : 2));
      check("t3_done", 64'(bus.done), 64'(k == 28));
      if (k == 5) begin
        bus.start = 1'b1; bus.seq_len = 8'd1;
        bus.wr_en = 1'b1; bus.wr_addr = 7'd2; bus.wr_data = 16'h0000;
      end else begin
        bus.start = 1'b0; bus.wr_en = 1'b0;
      end
      @(negedge clk);
    end
    check("t3_busy_end", 64'(bus.busy), 64'(0));

    // Abort during press.
    launch(16'h0210, 8'd1);
    repeat (3) @(negedge clk);
    check("ab_press", 64'(bus.keys), 64'(mk(2, 5'b10000)));
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("ab_keys", 64'(bus.keys), 64'(ALL1));
    check("ab_busy", 64'(bus.busy), 64'(0));
    for (int k = 0; k < 10; k++) begin
      check("ab_nodone", 64'(bus.done), 64'(0));
      @(negedge clk);
    end

    // Zero-length sequence.
    bus.seq_len = 8'd0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("z_done", 64'(bus.done), 64'(1));
    check("z_keys", 64'(bus.keys), 64'(ALL1));
    @(negedge clk);
    check("z_done_end", 64'(bus.done), 64'(0));
    check("z_busy_end", 64'(bus.busy), 64'(0));
    check("z_keys_end", 64'(bus.keys), 64'(ALL1));

    // CPU read port and asynchronous reset mid-press.
    launch(16'h030F, 8'd1);
    bus.row_sel = 8'b11110111;
    @(negedge clk);
    #1 check("kb_before", 64'(bus.kb_data), 64'(5'b11111));
    @(negedge clk);
    #1 check("kb_row3", 64'(bus.kb_data), 64'(5'b01111));
    bus.row_sel = 8'hFF;
    #1 check("kb_none", 64'(bus.kb_data), 64'(5'b11111));
    bus.row_sel = 8'h00;
    #1 check("kb_all", 64'(bus.kb_data), 64'(5'b01111));
    bus.row_sel = 8'b11111110;
    #1 check("kb_row0", 64'(bus.kb_data), 64'(5'b11111));
    @(negedge clk);
    check("rst_press", 64'(bus.keys), 64'(mk(3, 5'b01111)));
    #1 reset = 1'b0;
    #1 check("arst_keys", 64'(bus.keys), 64'(ALL1));
    check("arst_busy", 64'(bus.busy), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    bus.row_sel = 8'hFF;
    repeat (5) @(negedge clk);
    check("post_rst_keys", 64'(bus.keys), 64'(ALL1));
    check("post_rst_busy", 64'(bus.busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
